mask_reduce: RTL and testbench

Sequential, parametrised bitwise mask reducer, successor to the combinational two-input mask OR of P02. It accepts a programmed number of N-bit operands over a valid/ready stream and folds them with a selectable bitwise operation: OR, AND, XOR or AND-NOT. It delivers a registered result with a one-cycle done pulse. It sits between the operand source and the result/flag logic wherever multi-operand masking is needed.

---
 rtl/mask_reduce.sv | 128 ++++++++++++
 tb/tb_mask_reduce.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mask_reduce.sv
// rtl/mask_reduce.sv - sequential multi-operand bitwise mask reducer (OR/AND/XOR/ANDN)
module mask_reduce #(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic [N-1:0]     out_data,
    output logic             done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [N-1:0]     acc;
    logic [N-1:0]     acc_next;
    logic             beat;
    logic             last_beat;

    function automatic logic [N-1:0] fold(input logic [1:0] f,
                                          input logic [N-1:0] a,
                                          input logic [N-1:0] b);
        case (f)
            OP_OR:   fold = a | b;
            OP_AND:  fold = a & b;
            OP_XOR:  fold = a ^ b;
            default: fold = a & ~b;
        endcase
    endfunction

    assign beat = in_valid & in_ready;

    // The first beat of a job seeds the accumulator regardless of the operation.
    always_comb begin
        acc_next = acc;
        if (state == LOAD)
            acc_next = in_data;
        else
            acc_next = fold(op_q, acc, in_data);
    end

    always_comb begin
        last_beat = 1'b0;
        if (beat) begin
            if (state == LOAD)
                last_beat = (count_q == CNT_W'(1));
            else
                last_beat = ((beat_cnt + CNT_W'(1)) == count_q);
        end
    end

    // out_data is loaded on the final beat edge so it is already valid in the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            count_q  <= '0;
            beat_cnt <= '0;
            acc      <= '0;
            out_data <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            op_q     <= op;
                            count_q  <= count;
                            beat_cnt <= '0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD, ACCUM: begin
                    if (beat) begin
                        acc      <= acc_next;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (last_beat) begin
                            out_data <= acc_next;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                            state    <= DONE;
                        end else if (state == LOAD) begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_reduce.sv
// tb/tb_mask_reduce.sv - directed scoreboard bench for mask_reduce
module tb_mask_reduce;

    localparam int N     = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [CNT_W-1:0] count = '0;
    logic             in_valid = 1'b0;
    logic [N-1:0]     in_data = '0;
    logic             in_ready;
    logic [N-1:0]     out_data;
    logic             done;
    logic             busy;
    logic             err;

    int tests = 0;
    int fails = 0;
    logic [N-1:0] sb[$];

    mask_reduce #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_data(out_data), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns one cycle later with start released.
    task automatic start_job(input logic [1:0] o, input int c, input logic [N-1:0] exp);
        start = 1'b1;
        op    = o;
        count = CNT_W'(c);
        if (c != 0) sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [N-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int exp_wait);
        int waited = 0;
        logic [N-1:0] exp;
        while (done !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_latency"}, waited, exp_wait);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        check({tag, "_out"}, out_data, exp);
        check({tag, "_no_err"}, err, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out", out_data, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // OR, back-to-back beats
        start_job(2'b00, 3, 4'b1101);
        check("or_busy", busy, 1);
        check("or_ready", in_ready, 1);
        beat(4'b0001);
        beat(4'b0100);
        beat(4'b1000);
        wait_done("or", 0, 0);
        check("or_ready_done", in_ready, 0);
        @(negedge clk);
        check("or_done_pulse", done, 0);
        check("or_busy_after", busy, 0);

        // AND then ANDN; first result holds through second job
        start_job(2'b01, 3, 4'b0010);
        beat(4'b1111);
        beat(4'b1010);
        beat(4'b0110);
        wait_done("and", 0, 0);
        @(negedge clk);
        start_job(2'b11, 2, 4'b1010);
        check("andn_hold0", out_data, 4'b0010);
        beat(4'b1111);
        check("andn_hold1", out_data, 4'b0010);
        beat(4'b0101);
        wait_done("andn", 0, 0);
        @(negedge clk);

        // XOR with bubbles between beats
        start_job(2'b10, 2, 4'b0110);
        beat(4'b1100);
        repeat (3) begin
            check("xor_bubble_done", done, 0);
            check("xor_bubble_busy", busy, 1);
            @(negedge clk);
        end
        beat(4'b1010);
        wait_done("xor", 0, 0);
        @(negedge clk);

        // count=1 then count=0 error
        start_job(2'b10, 1, 4'b1001);
        beat(4'b1001);
        wait_done("c1", 0, 0);
        @(negedge clk);
        start_job(2'b00, 0, 4'b0000);
        check("c0_err", err, 1);
        check("c0_busy", busy, 0);
        check("c0_ready", in_ready, 0);
        check("c0_out", out_data, 4'b1001);
        check("c0_done", done, 0);
        @(negedge clk);
        check("c0_err_pulse", err, 0);
        check("c0_busy2", busy, 0);

        // start while busy is ignored
        start_job(2'b00, 2, 4'b0111);
        start = 1'b1;
        op    = 2'b01;
        count = CNT_W'(2);
        beat(4'b0011);
        beat(4'b0100);
        start = 1'b0;
        wait_done("busy_start", 0, 0);
        @(negedge clk);
        check("busy_start_idle", busy, 0);
        @(negedge clk);
        check("busy_start_idle2", busy, 0);
        check("busy_start_ready", in_ready, 0);

        // Asynchronous reset mid-job
        start_job(2'b00, 3, 4'b0000);
        beat(4'b0001);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", in_ready, 0);
        check("arst_out", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
        end
        start_job(2'b00, 2, 4'b0011);
        beat(4'b0001);
        beat(4'b0010);
        wait_done("post_rst", 0, 0);
        @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
